// File: rtl/bus_split_arbiter.sv
// rtl/bus_split_arbiter.sv - two-master bus arbiter with split-transaction park/resume
module bus_split_arbiter #(
  parameter int FAIR          = 0,
  parameter int SPLIT_TIMEOUT = 0,
  parameter int TO_WIDTH      = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic m1_breq,
  input  logic m2_breq,
  output logic m1_bgrant,
  output logic m2_bgrant,
  output logic msel,
  output logic m1_split,
  output logic m2_split,
  input  logic s_split,
  input  logic split_ready,
  output logic split_grant,
  output logic split_timeout,
  output logic busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_M1   = 2'd1;
  localparam logic [1:0] ST_M2   = 2'd2;

  // Last count value before a pending split is dropped.
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(SPLIT_TIMEOUT - 1);

  logic [1:0]          state, state_nx;
  logic                split_pend, split_pend_nx;
  logic                split_who, split_who_nx;
  logic                last_grant, last_grant_nx;
  logic                msel_nx;
  logic                split_grant_nx;
  logic                split_timeout_nx;
  logic [TO_WIDTH-1:0] to_cnt, to_cnt_nx;
  logic                m1_req_eff, m2_req_eff;
  logic                pick_m2;
  logic                owner_req;

  // Next-state decision: timeout bookkeeping, then grant/split/release by state.
  always_comb begin
    state_nx         = state;
    split_pend_nx    = split_pend;
    split_who_nx     = split_who;
    last_grant_nx    = last_grant;
    msel_nx          = msel;
    split_grant_nx   = 1'b0;
    split_timeout_nx = 1'b0;
    to_cnt_nx        = to_cnt;
    pick_m2          = 1'b0;
    owner_req        = (state == ST_M2) ? m2_breq : m1_breq;

    // A parked master cannot win a fresh arbitration; it only returns via resume.
    m1_req_eff = m1_breq && !(split_pend && !split_who);
    m2_req_eff = m2_breq && !(split_pend && split_who);

    if ((SPLIT_TIMEOUT > 0) && split_pend && !split_ready) begin
      if (to_cnt == TO_LAST) begin
        split_pend_nx    = 1'b0;
        split_timeout_nx = 1'b1;
        to_cnt_nx        = '0;
      end else if (to_cnt != '1) begin
        to_cnt_nx = to_cnt + 1'b1;
      end
    end

    case (state)
      ST_IDLE: begin
        if (split_pend && split_ready) begin
          state_nx       = split_who ? ST_M2 : ST_M1;
          msel_nx        = split_who;
          last_grant_nx  = split_who;
          split_pend_nx  = 1'b0;
          split_grant_nx = 1'b1;
          to_cnt_nx      = '0;
        end else if (m1_req_eff || m2_req_eff) begin
          if (m1_req_eff && m2_req_eff)
            pick_m2 = (FAIR != 0) && !last_grant;
          else
            pick_m2 = m2_req_eff;
          state_nx      = pick_m2 ? ST_M2 : ST_M1;
          msel_nx       = pick_m2;
          last_grant_nx = pick_m2;
        end
      end
      ST_M1, ST_M2: begin
        // Only one split can be parked; a second split request is ignored.
        if (s_split && !split_pend) begin
          state_nx      = ST_IDLE;
          split_pend_nx = 1'b1;
          split_who_nx  = (state == ST_M2);
          to_cnt_nx     = '0;
        end else if (!owner_req) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset clears everything without waiting for clk.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= ST_IDLE;
      split_pend    <= 1'b0;
      split_who     <= 1'b0;
      last_grant    <= 1'b1;
      to_cnt        <= '0;
      msel          <= 1'b0;
      m1_bgrant     <= 1'b0;
      m2_bgrant     <= 1'b0;
      m1_split      <= 1'b0;
      m2_split      <= 1'b0;
      split_grant   <= 1'b0;
      split_timeout <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nx;
      split_pend    <= split_pend_nx;
      split_who     <= split_who_nx;
      last_grant    <= last_grant_nx;
      to_cnt        <= to_cnt_nx;
      msel          <= msel_nx;
      m1_bgrant     <= (state_nx == ST_M1);
      m2_bgrant     <= (state_nx == ST_M2);
      m1_split      <= split_pend_nx && !split_who_nx;
      m2_split      <= split_pend_nx && split_who_nx;
      split_grant   <= split_grant_nx;
      split_timeout <= split_timeout_nx;
      busy          <= (state_nx != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_bus_split_arbiter.sv
// tb/tb_bus_split_arbiter.sv - randomized reference-model bench for bus_split_arbiter
module tb_bus_split_arbiter;

  logic clk = 1'b0;
  logic rstn;
  logic m1_breq, m2_breq, s_split, split_ready;

  logic a_m1g, a_m2g, a_msel, a_m1s, a_m2s, a_sg, a_sto, a_busy;
  logic b_m1g, b_m2g, b_msel, b_m1s, b_m2s, b_sg, b_sto, b_busy;
  logic [7:0] obs_a, obs_b;

  assign obs_a = {a_m1g, a_m2g, a_msel, a_m1s, a_m2s, a_sg, a_sto, a_busy};
  assign obs_b = {b_m1g, b_m2g, b_msel, b_m1s, b_m2s, b_sg, b_sto, b_busy};

  // Fixed priority, no timeout.
  bus_split_arbiter #(.FAIR(0), .SPLIT_TIMEOUT(0), .TO_WIDTH(16)) dut_a (
    .clk(clk), .rstn(rstn), .m1_breq(m1_breq), .m2_breq(m2_breq),
    .m1_bgrant(a_m1g), .m2_bgrant(a_m2g), .msel(a_msel),
    .m1_split(a_m1s), .m2_split(a_m2s), .s_split(s_split),
    .split_ready(split_ready), .split_grant(a_sg),
    .split_timeout(a_sto), .busy(a_busy)
  );

  // Round-robin, 8-cycle split timeout.
  bus_split_arbiter #(.FAIR(1), .SPLIT_TIMEOUT(8), .TO_WIDTH(4)) dut_b (
    .clk(clk), .rstn(rstn), .m1_breq(m1_breq), .m2_breq(m2_breq),
    .m1_bgrant(b_m1g), .m2_bgrant(b_m2g), .msel(b_msel),
    .m1_split(b_m1s), .m2_split(b_m2s), .s_split(s_split),
    .split_ready(split_ready), .split_grant(b_sg),
    .split_timeout(b_sto), .busy(b_busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: owner/parked are master numbers (0 = none), age counts
  // cycles a split has waited, last is the master granted most recently.
  int owner [2];
  int parked[2];
  int age   [2];
  int last  [2];
  bit mmsel [2];
  bit msg   [2];
  bit mto   [2];

  task automatic model_reset(input int i);
    owner[i] = 0; parked[i] = 0; age[i] = 0; last[i] = 2;
    mmsel[i] = 1'b0; msg[i] = 1'b0; mto[i] = 1'b0;
  endtask

  task automatic model_step(input int i, input bit fair, input int tmo,
                            input bit r1, input bit r2, input bit ss, input bit sr);
    int n_owner, n_parked, n_age, n_last, win;
    bit w1, w2;
    n_owner = owner[i]; n_parked = parked[i]; n_age = age[i]; n_last = last[i];
    msg[i] = 1'b0; mto[i] = 1'b0;
    if (tmo > 0 && parked[i] != 0 && !sr) begin
      if (age[i] + 1 >= tmo) begin
        n_parked = 0; mto[i] = 1'b1; n_age = 0;
      end else begin
        n_age = age[i] + 1;
      end
    end
    if (owner[i] == 0) begin
      if (parked[i] != 0 && sr) begin
        n_owner = parked[i]; n_last = parked[i]; n_parked = 0; n_age = 0;
        msg[i] = 1'b1; mmsel[i] = (parked[i] == 2);
      end else begin
        w1 = r1 && parked[i] != 1;
        w2 = r2 && parked[i] != 2;
        if (w1 && w2)  win = (fair && last[i] == 1) ? 2 : 1;
        else if (w1)   win = 1;
        else if (w2)   win = 2;
        else           win = 0;
        if (win != 0) begin
          n_owner = win; n_last = win; mmsel[i] = (win == 2);
        end
      end
    end else begin
      if (ss && parked[i] == 0) begin
        n_parked = owner[i]; n_age = 0; n_owner = 0;
      end else if (!((owner[i] == 1) ? r1 : r2)) begin
        n_owner = 0;
      end
    end
    owner[i] = n_owner; parked[i] = n_parked; age[i] = n_age; last[i] = n_last;
  endtask

  function automatic logic [7:0] expected(input int i);
    return {owner[i] == 1, owner[i] == 2, mmsel[i], parked[i] == 1, parked[i] == 2,
            msg[i], mto[i], owner[i] != 0};
  endfunction

  initial begin
    rstn = 1'b0; m1_breq = 1'b0; m2_breq = 1'b0; s_split = 1'b0; split_ready = 1'b0;
    model_reset(0);
    model_reset(1);
    #2;
    check_eq("reset_a", obs_a, 8'h00);
    check_eq("reset_b", obs_b, 8'h00);
    @(negedge clk);
    rstn = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc != 0) @(negedge clk);
      check_eq("fixed_prio", obs_a, expected(0));
      check_eq("round_robin", obs_b, expected(1));
      check_eq("one_hot_a", a_m1g & a_m2g, 1'b0);
      check_eq("one_hot_b", b_m1g & b_m2g, 1'b0);

      if ($urandom_range(0, 4) == 0) m1_breq = ~m1_breq;
      if ($urandom_range(0, 4) == 0) m2_breq = ~m2_breq;
      if ($urandom_range(0, 9) == 0) split_ready = ~split_ready;
      s_split = ($urandom_range(0, 5) == 0);

      // Occasional asynchronous reset mid-cycle, released before the next edge.
      if (cyc == 2000 || $urandom_range(0, 299) == 0) begin
        rstn = 1'b0;
        #1;
        check_eq("async_reset_a", obs_a, 8'h00);
        check_eq("async_reset_b", obs_b, 8'h00);
        model_reset(0);
        model_reset(1);
        #1;
        rstn = 1'b1;
      end

      model_step(0, 1'b0, 0, m1_breq, m2_breq, s_split, split_ready);
      model_step(1, 1'b1, 8, m1_breq, m2_breq, s_split, split_ready);
    end
    @(negedge clk);
    check_eq("final_a", obs_a, expected(0));
    check_eq("final_b", obs_b, expected(1));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
